// File: rtl/edit_controller_if.sv
// Edit bus between the key front-end and the time/date counter blocks:
// raw active-low buttons in, edit state and +/- strobes out.
interface edit_controller_if;
  logic       key_mode_n;
  logic       key_edit_n;
  logic       key_plus_n;
  logic       key_minus_n;
  logic       EditMode;
  logic [2:0] EditPos;
  logic [1:0] screen;
  logic       KeyPlus;
  logic       KeyMinus;
  logic       blink;

  // Controller side: samples buttons, drives the shared edit bus
  modport master (
    input  key_mode_n, key_edit_n, key_plus_n, key_minus_n,
    output EditMode, EditPos, screen, KeyPlus, KeyMinus, blink
  );

  // Button / counter side
  modport slave (
    output key_mode_n, key_edit_n, key_plus_n, key_minus_n,
    input  EditMode, EditPos, screen, KeyPlus, KeyMinus, blink
  );
endinterface

// File: rtl/edit_controller.sv
// View/edit front-end for the clock's time/date counters: per-key 2-FF
// synchronizer and debouncer, screen selection, cursor movement over the
// editable digits of the current screen, one-cycle +/- strobes and blink.
// Optional build macro EDIT_TIMEOUT_EN: leave edit mode after TIMEOUT_CYCLES
// without any debounced key press.
module edit_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 12_500_000,
  parameter int unsigned NUM_SCREENS     = 3,
  parameter logic [7:0]  EDIT_MASK_S0    = 8'h3F,
  parameter logic [7:0]  EDIT_MASK_S1    = 8'hFF,
  parameter logic [7:0]  EDIT_MASK_S2    = 8'h0F
`ifdef EDIT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  edit_controller_if.master bus
);

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned K_MINUS  = 0;
  localparam int unsigned K_PLUS   = 1;
  localparam int unsigned K_EDIT   = 2;
  localparam int unsigned K_MODE   = 3;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BL_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [1:0]  LAST_SCREEN = 2'(NUM_SCREENS - 1);
`ifdef EDIT_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

  typedef enum logic {S_VIEW, S_EDIT} state_t;

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] sync0;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] press;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];

  state_t          state_q, state_d;
  logic [2:0]      pos_q, pos_d;
  logic [1:0]      scr_q, scr_d;
  logic            plus_q, plus_d;
  logic            minus_q, minus_d;
  logic            blink_q, blink_d;
  logic [BL_W-1:0] bl_q, bl_d;
  logic [7:0]      mask_c;
`ifdef EDIT_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
`endif

  function automatic logic [7:0] mask_of(input logic [1:0] scr);
    case (scr)
      2'd0:    return EDIT_MASK_S0;
      2'd1:    return EDIT_MASK_S1;
      2'd2:    return EDIT_MASK_S2;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next set bit above pos, wrapping through 0; pos itself if it is the only one
  function automatic logic [2:0] next_bit(input logic [7:0] m, input logic [2:0] pos);
    logic [2:0] r;
    logic [2:0] c;
    logic       found;
    r     = pos;
    found = 1'b0;
    for (int i = 1; i < 8; i++) begin
      c = pos + 3'(i);
      if (!found && m[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign raw    = {bus.key_mode_n, bus.key_edit_n, bus.key_plus_n, bus.key_minus_n};
  assign mask_c = mask_of(scr_q);

  // Two-stage synchronizer for the asynchronous buttons (idle level is 1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= '1;
      sync1 <= '1;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
    end
  end

  // Debouncer: accept a level after it differs from stable for DEBOUNCE_CYCLES
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '1;
      press  <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        press[i] <= 1'b0;
        if (sync1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync1[i];
          db_cnt[i] <= '0;
          press[i]  <= ~sync1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_VIEW;
      pos_q   <= 3'd0;
      scr_q   <= 2'd0;
      plus_q  <= 1'b1;
      minus_q <= 1'b1;
      blink_q <= 1'b1;
      bl_q    <= '0;
`ifdef EDIT_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      scr_q   <= scr_d;
      plus_q  <= plus_d;
      minus_q <= minus_d;
      blink_q <= blink_d;
      bl_q    <= bl_d;
`ifdef EDIT_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  // Next-state: screen/cursor navigation, strobes, blink and inactivity timing
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    scr_d   = scr_q;
    plus_d  = 1'b1;
    minus_d = 1'b1;
    blink_d = blink_q;
    bl_d    = bl_q;
`ifdef EDIT_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      S_VIEW: begin
        pos_d   = 3'd0;
        blink_d = 1'b1;
        bl_d    = '0;
`ifdef EDIT_TIMEOUT_EN
        to_d    = '0;
`endif
        // Edit takes priority over a simultaneous mode press
        if (press[K_EDIT]) begin
          if (mask_c != 8'h00) begin
            state_d = S_EDIT;
            pos_d   = lowest_bit(mask_c);
          end
        end else if (press[K_MODE]) begin
          scr_d = (scr_q == LAST_SCREEN) ? 2'd0 : scr_q + 2'd1;
        end
      end
      S_EDIT: begin
        if (bl_q == BL_W'(BLINK_CYCLES - 1)) begin
          bl_d    = '0;
          blink_d = ~blink_q;
        end else begin
          bl_d = bl_q + 1'b1;
        end
`ifdef EDIT_TIMEOUT_EN
        to_d = (press != '0) ? '0 : to_q + 1'b1;
`endif
        if (press[K_MODE]) begin
          state_d = S_VIEW;
          pos_d   = 3'd0;
          blink_d = 1'b1;
          bl_d    = '0;
        end else begin
          if (press[K_EDIT]) begin
            pos_d   = next_bit(mask_c, pos_q);
            blink_d = 1'b1;
            bl_d    = '0;
          end
          // Contradictory +/- in one cycle is dropped
          if (press[K_PLUS] && !press[K_MINUS]) plus_d = 1'b0;
          if (press[K_MINUS] && !press[K_PLUS]) minus_d = 1'b0;
`ifdef EDIT_TIMEOUT_EN
          if ((press == '0) && (to_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
            state_d = S_VIEW;
            pos_d   = 3'd0;
            blink_d = 1'b1;
            bl_d    = '0;
            to_d    = '0;
          end
`endif
        end
      end
      default: state_d = S_VIEW;
    endcase
  end

  assign bus.EditMode = (state_q == S_EDIT);
  assign bus.EditPos  = pos_q;
  assign bus.screen   = scr_q;
  assign bus.KeyPlus  = plus_q;
  assign bus.KeyMinus = minus_q;
  assign bus.blink    = blink_q;

endmodule

// File: tb/tb_edit_controller.sv
// Directed bench for edit_controller: vector table of key presses with the
// resulting edit-bus state, plus timing sequences for debounce, strobe
// latency, blink, reset and (with EDIT_TIMEOUT_EN) the inactivity timeout.
module tb_edit_controller;

  // Active-high key sets {mode, edit, plus, minus}
  localparam logic [3:0] K_NONE = 4'b0000;
  localparam logic [3:0] K_M    = 4'b1000;
  localparam logic [3:0] K_E    = 4'b0100;
  localparam logic [3:0] K_P    = 4'b0010;
  localparam logic [3:0] K_N    = 4'b0001;

  typedef struct {
    logic [3:0] keys;
    logic       mode;
    logic [2:0] pos;
    logic [1:0] scr;
    int         np;
    int         nm;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  edit_controller_if bus ();

  edit_controller #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES(8)
`ifdef EDIT_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_keys(input logic [3:0] k);
    bus.key_mode_n  = ~k[3];
    bus.key_edit_n  = ~k[2];
    bus.key_plus_n  = ~k[1];
    bus.key_minus_n = ~k[0];
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_EditMode"}, int'(bus.EditMode), 0);
    check({tag, "_EditPos"},  int'(bus.EditPos),  0);
    check({tag, "_screen"},   int'(bus.screen),   0);
    check({tag, "_KeyPlus"},  int'(bus.KeyPlus),  1);
    check({tag, "_KeyMinus"}, int'(bus.KeyMinus), 1);
    check({tag, "_blink"},    int'(bus.blink),    1);
  endtask

  // Hold keys 12 cycles, release 12 cycles, counting strobe-low cycles
  task automatic apply(input logic [3:0] k, output int np, output int nm);
    np = 0;
    nm = 0;
    set_keys(k);
    for (int c = 0; c < 24; c++) begin
      if (c == 12) set_keys(K_NONE);
      tick();
      if (!bus.KeyPlus) np++;
      if (!bus.KeyMinus) nm++;
    end
  endtask

  task automatic press(input logic [3:0] k);
    int np, nm;
    apply(k, np, nm);
  endtask

  // Plus key pressed in cycle c when pat[c] is set; first = cycle of first strobe
  task automatic plus_pattern(input logic [63:0] pat, input int total,
                              output int np, output int nm, output int first);
    np = 0;
    nm = 0;
    first = -1;
    for (int c = 0; c < total; c++) begin
      set_keys(pat[c] ? K_P : K_NONE);
      tick();
      if (!bus.KeyPlus) begin
        np++;
        if (first < 0) first = c + 1;
      end
      if (!bus.KeyMinus) nm++;
    end
    set_keys(K_NONE);
  endtask

  function automatic vec_t mk(input logic [3:0] k, input int m, input int p,
                              input int s, input int np, input int nm);
    vec_t v;
    v.keys = k;
    v.mode = 1'(m);
    v.pos  = 3'(p);
    v.scr  = 2'(s);
    v.np   = np;
    v.nm   = nm;
    return v;
  endfunction

`ifdef EDIT_TIMEOUT_EN
  task automatic enter_edit_timed(output int ok);
    ok = 0;
    set_keys(K_E);
    for (int c = 0; c < 20 && ok == 0; c++) begin
      tick();
      if (bus.EditMode) ok = 1;
    end
    set_keys(K_NONE);
  endtask
`endif

  initial begin
    int         np, nm, first, last, ntog, mv, tog, ok, ex;
    logic       prevb;
    logic [2:0] p0;

    set_keys(K_NONE);
    reset = 1'b0;
    repeat (3) tick();
    check_reset("in_reset");
    reset = 1'b1;
    repeat (10) tick();
    check_reset("idle");

    // keys, EditMode, EditPos, screen, plus strobes, minus strobes
    vecs.push_back(mk(K_M,       0, 0, 1, 0, 0));
    vecs.push_back(mk(K_M,       0, 0, 2, 0, 0));
    vecs.push_back(mk(K_M,       0, 0, 0, 0, 0));
    vecs.push_back(mk(K_P,       0, 0, 0, 0, 0));
    vecs.push_back(mk(K_E,       1, 0, 0, 0, 0));
    vecs.push_back(mk(K_E,       1, 1, 0, 0, 0));
    vecs.push_back(mk(K_E,       1, 2, 0, 0, 0));
    vecs.push_back(mk(K_E,       1, 3, 0, 0, 0));
    vecs.push_back(mk(K_E,       1, 4, 0, 0, 0));
    vecs.push_back(mk(K_P,       1, 4, 0, 1, 0));
    vecs.push_back(mk(K_N,       1, 4, 0, 0, 1));
    vecs.push_back(mk(K_P | K_N, 1, 4, 0, 0, 0));
    vecs.push_back(mk(K_E,       1, 5, 0, 0, 0));
    vecs.push_back(mk(K_E,       1, 0, 0, 0, 0));
    vecs.push_back(mk(K_E | K_P, 1, 1, 0, 1, 0));
    vecs.push_back(mk(K_M | K_P, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_M | K_E, 1, 0, 0, 0, 0));
    vecs.push_back(mk(K_M,       0, 0, 0, 0, 0));
    vecs.push_back(mk(K_M,       0, 0, 1, 0, 0));
    vecs.push_back(mk(K_E,       1, 0, 1, 0, 0));
    vecs.push_back(mk(K_E,       1, 1, 1, 0, 0));
    vecs.push_back(mk(K_M | K_E, 0, 0, 1, 0, 0));
    vecs.push_back(mk(K_M,       0, 0, 2, 0, 0));
    vecs.push_back(mk(K_E,       1, 0, 2, 0, 0));
    vecs.push_back(mk(K_E,       1, 1, 2, 0, 0));
    vecs.push_back(mk(K_E,       1, 2, 2, 0, 0));
    vecs.push_back(mk(K_E,       1, 3, 2, 0, 0));
    vecs.push_back(mk(K_E,       1, 0, 2, 0, 0));
    vecs.push_back(mk(K_M,       0, 0, 2, 0, 0));
    vecs.push_back(mk(K_M,       0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].keys, np, nm);
      check($sformatf("vec%0d_EditMode", i), int'(bus.EditMode), int'(vecs[i].mode));
      check($sformatf("vec%0d_EditPos", i),  int'(bus.EditPos),  int'(vecs[i].pos));
      check($sformatf("vec%0d_screen", i),   int'(bus.screen),   int'(vecs[i].scr));
      check($sformatf("vec%0d_plus_cnt", i),  np, vecs[i].np);
      check($sformatf("vec%0d_minus_cnt", i), nm, vecs[i].nm);
    end

    // Debounce and strobe timing, cursor parked on position 4 of screen 0
    repeat (5) press(K_E);
    check("glitch_setup_mode", int'(bus.EditMode), 1);
    check("glitch_setup_pos", int'(bus.EditPos), 4);
    plus_pattern(64'h7, 14, np, nm, first);
    check("glitch_3cyc_strobes", np, 0);
    plus_pattern(64'h33, 16, np, nm, first);
    check("glitch_bounce_strobes", np, 0);
    plus_pattern((64'd1 << 20) - 64'd1, 30, np, nm, first);
    check("long20_strobes", np, 1);
    plus_pattern((64'd1 << 50) - 64'd1, 58, np, nm, first);
    check("hold50_strobes", np, 1);
    check("hold50_latency", first, 7);
    check("hold50_minus", nm, 0);
    check("hold50_pos", int'(bus.EditPos), 4);
    press(K_M);
    check("exit_mode", int'(bus.EditMode), 0);

    // Blink period in edit, restart on cursor move, reset on leaving edit
    press(K_E);
    check("blink_entry_mode", int'(bus.EditMode), 1);
    prevb = bus.blink;
    last = -1;
    ntog = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (bus.blink != prevb) begin
        if (last >= 0) check("blink_period", c - last, 8);
        last = c;
        ntog++;
        prevb = bus.blink;
      end
    end
    check("blink_toggles", ntog, 4);
    p0 = bus.EditPos;
    mv = -1;
    tog = -1;
    set_keys(K_E);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (mv >= 0 && tog < 0 && !bus.blink) tog = c;
      if (mv < 0 && bus.EditPos != p0) begin
        mv = c;
        check("blink_on_move", int'(bus.blink), 1);
        set_keys(K_NONE);
      end
    end
    set_keys(K_NONE);
    check("move_latency", mv, 7);
    check("move_pos", int'(bus.EditPos), 1);
    check("blink_restart", tog - mv, 8);
    press(K_M);
    check("leave_EditMode", int'(bus.EditMode), 0);
    check("leave_EditPos", int'(bus.EditPos), 0);
    check("leave_blink", int'(bus.blink), 1);
    check("leave_screen", int'(bus.screen), 0);

`ifdef EDIT_TIMEOUT_EN
    // Inactivity timeout, then restart of the count by a press
    enter_edit_timed(ok);
    check("to_enter1", ok, 1);
    ex = -1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      if (ex < 0 && !bus.EditMode) ex = t;
    end
    check("to_exit_cycle", ex, 64);
    check("to_exit_pos", int'(bus.EditPos), 0);
    check("to_exit_blink", int'(bus.blink), 1);
    enter_edit_timed(ok);
    check("to_enter2", ok, 1);
    ex = -1;
    for (int t = 1; t <= 140; t++) begin
      tick();
      if (t == 53) set_keys(K_P);
      if (t == 63) set_keys(K_NONE);
      if (ex < 0 && !bus.EditMode) ex = t;
    end
    check("to_restart_exit_cycle", ex, 124);
`else
    // Without the timeout, edit mode persists while idle
    press(K_E);
    repeat (200) tick();
    check("persist_mode", int'(bus.EditMode), 1);
    press(K_M);
    check("persist_exit", int'(bus.EditMode), 0);
`endif

    // Asynchronous reset mid-debounce with a key held, in edit on screen 1
    press(K_M);
    press(K_E);
    press(K_E);
    check("pre_reset_mode", int'(bus.EditMode), 1);
    check("pre_reset_pos", int'(bus.EditPos), 1);
    check("pre_reset_screen", int'(bus.screen), 1);
    set_keys(K_P);
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check_reset("reset_mid");
    set_keys(K_NONE);
    repeat (3) tick();
    reset = 1'b1;
    repeat (12) tick();
    check_reset("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
